// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package fetch_sequencer_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned IMM_WIDTH  = 24;

  typedef enum logic [1:0] {
    FETCH_S  = 2'd0,
    STALL_S  = 2'd1,
    HALTED_S = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response and IF/ID pipeline register bundle.
interface fetch_sequencer_if #(
  parameter int unsigned WORD_WIDTH = 32
);

  logic [WORD_WIDTH-1:0] imem_addr;
  logic [WORD_WIDTH-1:0] imem_instr;
  logic                  if_id_valid;
  logic [WORD_WIDTH-1:0] if_id_instr;
  logic [WORD_WIDTH-1:0] if_id_pc;

  modport master (
    output imem_addr,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    input  imem_instr
  );

  modport slave (
    input  imem_addr,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    output imem_instr
  );

endinterface

// File: rtl/fetch_sequencer_branch_target_adder.sv
// Branch target = branch_pc + 1 + sign_extend(imm), plus a branch-to-self flag.
module branch_target_adder #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 24
) (
  input  logic [WORD_WIDTH-1:0] branch_pc,
  input  logic [IMM_WIDTH-1:0]  branch_imm,
  output logic [WORD_WIDTH-1:0] target,
  output logic                  is_self
);

  logic [WORD_WIDTH-1:0] imm_ext;

  assign imm_ext = {{(WORD_WIDTH - IMM_WIDTH){branch_imm[IMM_WIDTH-1]}}, branch_imm};
  assign target  = branch_pc + imm_ext + WORD_WIDTH'(1);
  assign is_self = (target == branch_pc);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, drives imem, fills IF/ID, handles stall/redirect/halt.
module fetch_sequencer #(
  parameter int unsigned WORD_WIDTH          = fetch_sequencer_pkg::WORD_WIDTH,
  parameter int unsigned IMM_WIDTH           = fetch_sequencer_pkg::IMM_WIDTH,
  parameter int unsigned RESET_PC            = 0,
  parameter bit          HALT_ON_SELF_BRANCH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [IMM_WIDTH-1:0]  branch_imm,
  input  logic [WORD_WIDTH-1:0] branch_pc,
  fetch_sequencer_if.master     fif,
  output logic                  halted,
  output logic [WORD_WIDTH-1:0] fetch_count
);

  import fetch_sequencer_pkg::*;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;
  logic [WORD_WIDTH-1:0] ifpc_q, ifpc_d;
  logic                  halted_q, halted_d;
  logic [WORD_WIDTH-1:0] count_q, count_d;
  logic [WORD_WIDTH-1:0] target;
  logic                  is_self;
  logic [WORD_WIDTH-1:0] pc_inc;

  branch_target_adder #(
    .WORD_WIDTH (WORD_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_target (
    .branch_pc  (branch_pc),
    .branch_imm (branch_imm),
    .target     (target),
    .is_self    (is_self)
  );

  assign pc_inc = pc_q + WORD_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_S;
      pc_q     <= WORD_WIDTH'(RESET_PC);
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ifpc_q   <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // STALL behaves exactly like FETCH; it only records that the last edge was frozen.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    halted_d = halted_q;
    count_d  = count_q;
    unique case (state_q)
      HALTED_S: begin
        valid_d = 1'b0;
      end
      default: begin
        if (branch_taken) begin
          pc_d    = target;
          valid_d = 1'b0;
          if (HALT_ON_SELF_BRANCH && is_self) begin
            state_d  = HALTED_S;
            halted_d = 1'b1;
          end else begin
            state_d = FETCH_S;
          end
        end else if (freeze) begin
          state_d = STALL_S;
        end else begin
          pc_d    = pc_inc;
          instr_d = fif.imem_instr;
          ifpc_d  = pc_inc;
          valid_d = 1'b1;
          state_d = FETCH_S;
          if (count_q != '1) begin
            count_d = count_q + WORD_WIDTH'(1);
          end
        end
      end
    endcase
  end

  assign fif.imem_addr   = pc_q;
  assign fif.if_id_valid = valid_q;
  assign fif.if_id_instr = instr_q;
  assign fif.if_id_pc    = ifpc_q;
  assign halted          = halted_q;
  assign fetch_count     = count_q;

endmodule
